// File: rtl/mii_rx_framer.sv
// MII receive framer: preamble/SFD strip, nibble-to-byte assembly, FCS and length check.
// MII_RX_FCS_STRIP_EN withholds the four FCS bytes from the output stream.
module mii_rx_framer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic       phy_smii_ref_clk,
  input  logic       rst_async,
  input  logic       mii_rxc,
  input  logic       mii_rxdv,
  input  logic       mii_rxer,
  input  logic [3:0] mii_rxd,
  output logic       m_tvalid,
  output logic [7:0] m_tdata,
  output logic       m_tlast,
  output logic       m_tuser,
  output logic       stat_good,
  output logic       stat_bad
);

`ifdef MII_RX_FCS_STRIP_EN
  localparam int unsigned D = 5;
`else
  localparam int unsigned D = 1;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PRE  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
  localparam logic [10:0] D_L         = 11'(D);

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  logic        rxc_r;
  logic        s;
  logic [1:0]  state;
  logic        phase;
  logic [3:0]  low_nib;
  logic [10:0] len;
  logic        err;
  logic [31:0] crc;
  logic [7:0]  dly [D];
  logic [7:0]  byte_in;
  logic        frame_bad;

  assign s       = mii_rxc & ~rxc_r;
  assign byte_in = {mii_rxd, low_nib};

  // Evaluated at the end-of-frame sample; the CRC already includes the last FCS byte.
  assign frame_bad = err | phase | (crc != CRC_RESIDUE) | (len < MIN_L) | (len > MAX_L);

  always_ff @(posedge phy_smii_ref_clk or posedge rst_async) begin
    if (rst_async) begin
      rxc_r     <= 1'b0;
      state     <= IDLE;
      phase     <= 1'b0;
      low_nib   <= '0;
      len       <= '0;
      err       <= 1'b0;
      crc       <= '0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tlast   <= 1'b0;
      m_tuser   <= 1'b0;
      stat_good <= 1'b0;
      stat_bad  <= 1'b0;
      for (int unsigned i = 0; i < D; i++) dly[i] <= '0;
    end else begin
      rxc_r     <= mii_rxc;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tuser   <= 1'b0;
      stat_good <= 1'b0;
      stat_bad  <= 1'b0;
      if (s) begin
        case (state)
          IDLE: begin
            if (mii_rxdv) state <= (mii_rxd == 4'h5) ? PRE : DROP;
          end
          PRE: begin
            if (!mii_rxdv) begin
              state <= IDLE;
            end else if (mii_rxd == 4'hD) begin
              state <= DATA;
              phase <= 1'b0;
              len   <= '0;
              err   <= 1'b0;
              crc   <= '1;
            end else if (mii_rxd != 4'h5) begin
              state <= DROP;
            end
          end
          DATA: begin
            if (!mii_rxdv) begin
              state <= IDLE;
              // Oldest held byte closes the frame; the newer D-1 bytes are dropped.
              if (len > D_L) begin
                m_tvalid <= 1'b1;
                m_tdata  <= dly[D-1];
                m_tlast  <= 1'b1;
                m_tuser  <= frame_bad;
              end
              stat_good <= ~frame_bad;
              stat_bad  <= frame_bad;
            end else begin
              if (mii_rxer) err <= 1'b1;
              phase <= ~phase;
              if (!phase) begin
                low_nib <= mii_rxd;
              end else begin
                crc <= crc_byte(crc, byte_in);
                if (len != '1) len <= len + 11'd1;
                for (int unsigned i = D - 1; i > 0; i--) dly[i] <= dly[i-1];
                dly[0] <= byte_in;
                if (len >= D_L) begin
                  m_tvalid <= 1'b1;
                  m_tdata  <= dly[D-1];
                end
              end
            end
          end
          default: begin
            if (!mii_rxdv) state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mii_rx_framer.sv
// Directed bench for mii_rx_framer; honours MII_RX_FCS_STRIP_EN for the expected stream.
module tb_mii_rx_framer;

`ifdef MII_RX_FCS_STRIP_EN
  localparam int D = 5;
`else
  localparam int D = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_async = 1'b1;
  logic       mii_rxc = 1'b0;
  logic       mii_rxdv = 1'b0;
  logic       mii_rxer = 1'b0;
  logic [3:0] mii_rxd = 4'h0;
  logic       m_tvalid;
  logic [7:0] m_tdata;
  logic       m_tlast;
  logic       m_tuser;
  logic       stat_good;
  logic       stat_bad;

  mii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1522)) dut (
    .phy_smii_ref_clk(clk),
    .rst_async(rst_async),
    .mii_rxc(mii_rxc),
    .mii_rxdv(mii_rxdv),
    .mii_rxer(mii_rxer),
    .mii_rxd(mii_rxd),
    .m_tvalid(m_tvalid),
    .m_tdata(m_tdata),
    .m_tlast(m_tlast),
    .m_tuser(m_tuser),
    .stat_good(stat_good),
    .stat_bad(stat_bad)
  );

  always #4 clk = ~clk;

  // Output monitor: records every beat and stat pulse.
  logic [7:0] cap [4096];
  bit         tl  [4096];
  bit         tu  [4096];
  bit         st  [4096];
  int         bt  [4096];
  int         nbeat = 0;
  int         ngood = 0;
  int         nbad  = 0;
  int         cyc   = 0;

  always @(negedge clk) begin
    cyc++;
    if (m_tvalid === 1'b1 && nbeat < 4096) begin
      cap[nbeat] = m_tdata;
      tl[nbeat]  = m_tlast;
      tu[nbeat]  = m_tuser;
      st[nbeat]  = stat_good | stat_bad;
      bt[nbeat]  = cyc;
      nbeat++;
    end
    if (stat_good === 1'b1) ngood++;
    if (stat_bad === 1'b1) nbad++;
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] fr [0:1599];
  int         b0, g0, k0, rbase;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Payload pattern i^0xA0, then FCS = complemented reflected CRC-32 sent LSB first.
  task automatic build(input int n, input bit corrupt);
    logic [31:0] c;
    logic [31:0] fcs;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - 4; i++) begin
      fr[i] = 8'(i) ^ 8'hA0;
      c = c ^ {24'h0, fr[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    fcs = ~c;
    for (int k = 0; k < 4; k++) fr[n-4+k] = fcs[8*k +: 8];
    if (corrupt) fr[5] = fr[5] ^ 8'h10;
  endtask

  task automatic nib(input bit dv, input bit er, input logic [3:0] d,
                     input int lo, input int hi, input bit do_rst);
    @(negedge clk);
    mii_rxdv = dv; mii_rxer = er; mii_rxd = d; mii_rxc = 1'b0;
    repeat (lo - 1) @(negedge clk);
    @(negedge clk);
    mii_rxc = 1'b1;
    if (do_rst) begin
      @(negedge clk);
      chk("rst_pre_tvalid", m_tvalid, 1);
      rst_async = 1'b1;
      #1;
      chk("rst_async_outputs", {m_tvalid, m_tdata, m_tlast, m_tuser, stat_good, stat_bad}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_async = 1'b0;
      rbase = nbeat;
    end else begin
      repeat (hi - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int n, input int lo, input int hi, input int bad_pre,
                            input int er_nib, input bit extra, input int rst_byte,
                            input bit exp_stat);
    logic [7:0] bv;
    b0 = nbeat; g0 = ngood; k0 = nbad;
    for (int i = 0; i < 15; i++) nib(1'b1, 1'b0, (i == bad_pre) ? 4'h7 : 4'h5, lo, hi, 1'b0);
    nib(1'b1, 1'b0, 4'hD, lo, hi, 1'b0);
    for (int b = 0; b < n; b++) begin
      bv = fr[b];
      nib(1'b1, er_nib == 2*b, bv[3:0], lo, hi, 1'b0);
      nib(1'b1, er_nib == 2*b + 1, bv[7:4], lo, hi, rst_byte == b);
    end
    if (extra) nib(1'b1, 1'b0, 4'h3, lo, hi, 1'b0);
    @(negedge clk);
    mii_rxdv = 1'b0; mii_rxer = 1'b0; mii_rxd = 4'h0; mii_rxc = 1'b0;
    repeat (lo - 1) @(negedge clk);
    @(negedge clk);
    mii_rxc = 1'b1;
    @(negedge clk);
    chk("eof_stat_latency", stat_good | stat_bad, exp_stat);
    chk("eof_tlast_latency", m_tvalid & m_tlast, exp_stat && (n > D));
    repeat (20) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int n, input bit eu, input bit eg,
                             input int min_gap);
    int nb, eb, mism, tlc, mg;
    nb = nbeat - b0;
    eb = n - D + 1;
    chk({tag, "_beats"}, nb, eb);
    mism = 0;
    for (int i = 0; i < nb && i < eb; i++) if (cap[b0+i] !== fr[i]) mism++;
    chk({tag, "_data_mismatches"}, mism, 0);
    if (nb > 0) begin
      tlc = 0;
      for (int i = 0; i < nb; i++) tlc += int'(tl[b0+i]);
      chk({tag, "_tlast_count"}, tlc, 1);
      chk({tag, "_tlast_pos"}, tl[b0+nb-1], 1);
      chk({tag, "_tuser"}, tu[b0+nb-1], eu);
      chk({tag, "_stat_on_last"}, st[b0+nb-1], 1);
    end
    chk({tag, "_stat_good"}, ngood - g0, eg);
    chk({tag, "_stat_bad"}, nbad - k0, !eg);
    if (min_gap > 0 && nb > 2) begin
      mg = 1 << 30;
      for (int i = 1; i < nb - 1; i++) if (bt[b0+i] - bt[b0+i-1] < mg) mg = bt[b0+i] - bt[b0+i-1];
      chk({tag, "_min_gap_ok"}, mg >= min_gap, 1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tvalid", m_tvalid, 0);
    chk("reset_tdata", m_tdata, 0);
    chk("reset_tlast", m_tlast, 0);
    chk("reset_tuser", m_tuser, 0);
    chk("reset_stat_good", stat_good, 0);
    chk("reset_stat_bad", stat_bad, 0);
    rst_async = 1'b0;
    repeat (5) @(negedge clk);

    build(64, 1'b0);
    send_frame(64, 2, 3, -1, -1, 1'b0, -1, 1'b1);
    check_frame("good100", 64, 1'b0, 1'b1, 10);

    send_frame(64, 25, 25, -1, -1, 1'b0, -1, 1'b1);
    check_frame("good10", 64, 1'b0, 1'b1, 100);

    build(64, 1'b1);
    send_frame(64, 2, 3, -1, -1, 1'b0, -1, 1'b1);
    check_frame("badcrc", 64, 1'b1, 1'b0, 0);

    build(64, 1'b0);
    send_frame(64, 2, 3, -1, 41, 1'b0, -1, 1'b1);
    check_frame("rxer", 64, 1'b1, 1'b0, 0);

    send_frame(64, 2, 3, -1, -1, 1'b1, -1, 1'b1);
    check_frame("dribble", 64, 1'b1, 1'b0, 0);

    build(60, 1'b0);
    send_frame(60, 2, 3, -1, -1, 1'b0, -1, 1'b1);
    check_frame("short60", 60, 1'b1, 1'b0, 0);

    build(1523, 1'b0);
    send_frame(1523, 2, 3, -1, -1, 1'b0, -1, 1'b1);
    check_frame("long1523", 1523, 1'b1, 1'b0, 0);

    build(64, 1'b0);
    send_frame(64, 2, 3, 3, -1, 1'b0, -1, 1'b0);
    chk("badpre_beats", nbeat - b0, 0);
    chk("badpre_stats", (ngood - g0) + (nbad - k0), 0);
    send_frame(64, 2, 3, -1, -1, 1'b0, -1, 1'b1);
    check_frame("after_badpre", 64, 1'b0, 1'b1, 0);

    send_frame(64, 2, 3, -1, -1, 1'b0, 18, 1'b0);
    chk("rst_beats_after_release", nbeat - rbase, 0);
    chk("rst_stats", (ngood - g0) + (nbad - k0), 0);
    send_frame(64, 2, 3, -1, -1, 1'b0, -1, 1'b1);
    check_frame("after_rst", 64, 1'b0, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
